gps_sv_scheduler: RTL and testbench
===================================

# gps_sv_scheduler

Round-robin sequencer that shares one `gps` code-generator core between up to 32 satellite vehicles (SVs). It walks an SV enable mask, drives the core's `sv_num`/`start` inputs, waits for the core's `l_code_valid` rising edge, captures the C/A, P and L code words tagged with their SV, and offers them downstream over a valid/ready handshake. It sits between the register/bus front end and the `gps` core.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 4096: RUN-state cycle limit before abandoning an SV (used only with `GPS_SCHED_TIMEOUT_EN`).
- `TO_W`, 13: timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: level; scheduler runs while high.
- `sv_mask` in 32: bit i enables SV i+1.
- `gps_sv_num` out 6: SV number to core (1..32).
- `gps_start` out 1: start level to core.
- `gps_ca_code` in 13, `gps_p_code` in 128, `gps_l_code` in 128: core outputs.
- `gps_l_code_valid` in 1: core completion flag.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_sv` out 6, `res_ca` out 13, `res_p` out 128, `res_l` out 128: captured result.
- `busy` out 1: state not IDLE.
- `err_clr` in 1: clears `timeout_err`.
- `timeout_err` out 1, `timeout_sv` out 6: sticky timeout flag and offending SV.

## Operation
- States: IDLE, SELECT, RUN, HOLD.
- IDLE: `enable`=1 -> SELECT.
- SELECT (1 cycle): sample `sv_mask`; pick lowest set bit strictly above `last_sv`, wrapping to bit 0. Mask zero -> IDLE. Else load `gps_sv_num`, `last_sv`; -> RUN. `last_sv` resets to 32 so first pick is the lowest set bit.
- RUN: `gps_start`=1. Completion = `gps_l_code_valid`=1 while its registered previous value was 0 (rising edge). On completion: capture all three code words and `gps_sv_num` into result regs, drop `gps_start`, -> HOLD.
- HOLD: `res_valid`=1, result regs stable. Transfer when `res_valid`&`res_ready`; next state SELECT if `enable`=1, else IDLE.
- `enable` falling in SELECT -> IDLE; in RUN or HOLD the current SV completes/delivers first.
- `sv_mask` changes only take effect at the next SELECT.
- Core `l_code_valid` edges outside RUN are ignored.
- Reset mid-operation: all state/outputs return to reset values immediately; in-flight result is discarded.

## Timing
- Reset values: `gps_sv_num`=0, `gps_start`=0, `res_valid`=0, `res_sv`/`res_ca`/`res_p`/`res_l`=0, `busy`=0, `timeout_err`=0, `timeout_sv`=0.
- `enable` sampled at edge N -> SELECT at N+1 -> `gps_start`=1 from N+2.
- Completion edge seen at edge M -> `res_valid`=1 and `gps_start`=0 from M+1.
- Handshake at edge K -> `res_valid`=0 at K+1; next SV's `gps_start`=1 at K+2.
- `res_ready` may be held high permanently; no combinational path from `res_ready` to `res_valid`.
- `err_clr` and a new timeout in the same cycle: set wins.

## Configuration
- `GPS_SCHED_TIMEOUT_EN` defined: RUN counts cycles from 0; at count == TIMEOUT_CYCLES-1 without completion, drop `gps_start`, set `timeout_err`, load `timeout_sv`=`gps_sv_num`, no result produced, -> SELECT (or IDLE if `enable`=0). Counter clears on entering RUN.
- Undefined: no counter; RUN waits indefinitely; `timeout_err`, `timeout_sv` tied 0; `err_clr` unused.

## Structure
- Shared package `gps_pkg`: state enum, `SV_NUM_W`=6, `NUM_SV`=32, `CA_W`=13, `PL_W`=128.
- One sub-module `gps_rr_pick`: combinational 32-bit round-robin next-set-bit finder (mask, last_sv -> next_sv, found).

## Test plan
- `sv_mask`=0x0000_0005, `enable`=1, core model asserts valid 100 cycles after start -> results for SV 1 then SV 3 then SV 1, `gps_start` at exact cycles above.
- `res_ready` held low 50 cycles in HOLD -> `res_valid` and all `res_*` stable; `gps_start` stays 0; no new SV started.
- `sv_mask`=0 with `enable`=1 -> SELECT then IDLE, `gps_start` never asserts, `busy` pulses one cycle.
- `enable` dropped mid-RUN for SV 7 -> SV 7 result delivered, then IDLE; `busy`=0.
- `GPS_SCHED_TIMEOUT_EN`, TIMEOUT_CYCLES=16, core never completes SV 5 -> after 16 RUN cycles `timeout_err`=1, `timeout_sv`=5, next enabled SV starts; `err_clr` clears flag.
- Assert `rst` during HOLD -> all outputs zero next sample; after release with `enable`=1, lowest enabled SV served first.

Source files
------------

// File: rtl/gps_pkg.sv
// Shared types and sizes for the GPS SV scheduler slice.
package gps_pkg;

  localparam int SV_NUM_W = 6;
  localparam int NUM_SV   = 32;
  localparam int CA_W     = 13;
  localparam int PL_W     = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_RUN,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/gps_sv_scheduler_if.sv
// Result bus from the scheduler to its consumer.
// Handshake: a word moves on every rising clk edge where res_valid and res_ready
// are both high; res_valid never depends on res_ready, and the res_* words stay
// stable while res_valid is high and res_ready is low.
interface gps_sv_scheduler_if;
  import gps_pkg::*;

  logic                res_valid;
  logic                res_ready;
  logic [SV_NUM_W-1:0] res_sv;
  logic [CA_W-1:0]     res_ca;
  logic [PL_W-1:0]     res_p;
  logic [PL_W-1:0]     res_l;

  modport master (output res_valid, res_sv, res_ca, res_p, res_l, input res_ready);
  modport slave  (input res_valid, res_sv, res_ca, res_p, res_l, output res_ready);

endinterface

// File: rtl/gps_rr_pick.sv
// Round-robin finder: lowest set mask bit strictly above last_sv, wrapping to bit 0.
// SV numbers are 1-based, so last_sv = k means the search starts at bit index k.
module gps_rr_pick
  import gps_pkg::*;
(
  input  logic [NUM_SV-1:0]   mask,
  input  logic [SV_NUM_W-1:0] last_sv,
  output logic [SV_NUM_W-1:0] next_sv,
  output logic                found
);

  logic [4:0] start_idx;
  logic [4:0] idx;

  // last_sv = 32 (reset value) starts the search at bit 0.
  assign start_idx = (last_sv >= SV_NUM_W'(NUM_SV)) ? 5'd0 : last_sv[4:0];

  always_comb begin
    next_sv = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_SV; i++) begin
      idx = start_idx + i[4:0];
      if (!found && mask[idx]) begin
        found   = 1'b1;
        next_sv = {1'b0, idx} + SV_NUM_W'(1);
      end
    end
  end

endmodule

// File: rtl/gps_sv_scheduler.sv
// Round-robin sequencer sharing one gps code core across up to 32 SVs.
// Optional RUN timeout is enabled by defining GPS_SCHED_TIMEOUT_EN.
module gps_sv_scheduler
  import gps_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 13
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [NUM_SV-1:0]   sv_mask,
  output logic [SV_NUM_W-1:0] gps_sv_num,
  output logic                gps_start,
  input  logic [CA_W-1:0]     gps_ca_code,
  input  logic [PL_W-1:0]     gps_p_code,
  input  logic [PL_W-1:0]     gps_l_code,
  input  logic                gps_l_code_valid,
  gps_sv_scheduler_if.master  res,
  output logic                busy,
  input  logic                err_clr,
  output logic                timeout_err,
  output logic [SV_NUM_W-1:0] timeout_sv,
  output state_t              state_dbg
);

  state_t              state, state_nxt;
  logic [SV_NUM_W-1:0] last_sv;
  logic [SV_NUM_W-1:0] pick_sv;
  logic                pick_found;
  logic                lcv_q;
  logic                done;
  logic                to_hit;

  gps_rr_pick u_pick (
    .mask    (sv_mask),
    .last_sv (last_sv),
    .next_sv (pick_sv),
    .found   (pick_found)
  );

  // Only a fresh rising edge of the core's valid flag while running counts.
  assign done = (state == ST_RUN) && gps_l_code_valid && !lcv_q;

`ifdef GPS_SCHED_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  assign to_hit = (state == ST_RUN) && !done && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
      timeout_sv  <= '0;
    end else begin
      if (state == ST_SELECT)
        to_cnt <= '0;
      else if (state == ST_RUN)
        to_cnt <= to_cnt + 1'b1;
      // A new timeout outranks a simultaneous clear.
      if (to_hit) begin
        timeout_err <= 1'b1;
        timeout_sv  <= gps_sv_num;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end
`else
  logic unused_cfg;

  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
  assign timeout_sv  = '0;
  assign unused_cfg  = err_clr ^ ((TIMEOUT_CYCLES + TO_W) != 0);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (enable) state_nxt = ST_SELECT;
      ST_SELECT: state_nxt = (enable && pick_found) ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        if (done)        state_nxt = ST_HOLD;
        else if (to_hit) state_nxt = enable ? ST_SELECT : ST_IDLE;
      end
      ST_HOLD:   if (res.res_ready) state_nxt = enable ? ST_SELECT : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_sv    <= SV_NUM_W'(NUM_SV);
      gps_sv_num <= '0;
      lcv_q      <= 1'b0;
      res.res_sv <= '0;
      res.res_ca <= '0;
      res.res_p  <= '0;
      res.res_l  <= '0;
    end else begin
      state <= state_nxt;
      lcv_q <= gps_l_code_valid;
      if (state == ST_SELECT && enable && pick_found) begin
        gps_sv_num <= pick_sv;
        last_sv    <= pick_sv;
      end
      if (done) begin
        res.res_sv <= gps_sv_num;
        res.res_ca <= gps_ca_code;
        res.res_p  <= gps_p_code;
        res.res_l  <= gps_l_code;
      end
    end
  end

  assign gps_start     = (state == ST_RUN);
  assign res.res_valid = (state == ST_HOLD);
  assign busy          = (state != ST_IDLE);
  assign state_dbg     = state;

endmodule

// File: tb/tb_gps_sv_scheduler.sv
// Self-checking bench for gps_sv_scheduler: cycle reference model, result scoreboard,
// directed scenarios followed by randomized traffic.
module tb_gps_sv_scheduler;
  import gps_pkg::*;

  localparam int W      = SV_NUM_W + CA_W + 2 * PL_W;
  localparam int TO_CYC = 16;
`ifdef GPS_SCHED_TIMEOUT_EN
  localparam int LONG_DLY = 10;
`else
  localparam int LONG_DLY = 100;
`endif
  localparam int P_IDLE = 0, P_SELECT = 1, P_RUN = 2, P_HOLD = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                enable, err_clr, gps_start, busy, timeout_err, gps_l_code_valid;
  logic [NUM_SV-1:0]   sv_mask;
  logic [SV_NUM_W-1:0] gps_sv_num, timeout_sv;
  logic [CA_W-1:0]     gps_ca_code;
  logic [PL_W-1:0]     gps_p_code, gps_l_code;
  state_t              dbg_state;

  gps_sv_scheduler_if res_if ();

  gps_sv_scheduler #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(13)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sv_mask(sv_mask),
    .gps_sv_num(gps_sv_num), .gps_start(gps_start),
    .gps_ca_code(gps_ca_code), .gps_p_code(gps_p_code), .gps_l_code(gps_l_code),
    .gps_l_code_valid(gps_l_code_valid), .res(res_if), .busy(busy),
    .err_clr(err_clr), .timeout_err(timeout_err), .timeout_sv(timeout_sv),
    .state_dbg(dbg_state)
  );

  // ---------------- core model (stimulus) ----------------
  int          core_delay = LONG_DLY;
  int          core_cnt = 0;
  logic        core_v = 1'b0, spur = 1'b0, spur_en = 1'b0;
  logic [31:0] stall_mask = '0;

  assign gps_l_code_valid = core_v | spur;

  always @(posedge clk) begin
    gps_ca_code <= CA_W'($urandom);
    gps_p_code  <= {$urandom, $urandom, $urandom, $urandom};
    gps_l_code  <= {$urandom, $urandom, $urandom, $urandom};
    spur        <= spur_en && !gps_start && ($urandom_range(0, 7) == 0);
    if (!gps_start) begin
      core_cnt <= 0;
      core_v   <= 1'b0;
    end else if (gps_sv_num == 0 || !stall_mask[gps_sv_num - 1]) begin
      if (core_cnt >= core_delay - 1) core_v <= 1'b1;
      else core_cnt <= core_cnt + 1;
    end
  end

  // ---------------- checking infrastructure ----------------
  int n_tests = 0, n_fail = 0;
  logic [W-1:0] exp_q[$];
  int served_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_pick(input logic [31:0] mask, input int last);
    int cand;
    for (int k = 1; k <= 32; k++) begin
      cand = ((last + k - 1) % 32) + 1;
      if (mask[cand - 1]) return cand;
    end
    return 0;
  endfunction

  // ---------------- reference model ----------------
  int           m_phase, m_last, m_sv, m_cnt, m_tsv, pick;
  logic         m_prev, m_terr, m_done, m_fire;
  logic [W-1:0] m_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = P_IDLE; m_last = 32; m_sv = 0; m_cnt = 0; m_tsv = 0;
      m_prev = 1'b0; m_terr = 1'b0; m_res = '0;
      exp_q.delete();
    end else begin
      m_done = (m_phase == P_RUN) && gps_l_code_valid && !m_prev;
      m_fire = 1'b0;
      m_prev = gps_l_code_valid;
      case (m_phase)
        P_IDLE: if (enable) m_phase = P_SELECT;
        P_SELECT: begin
          pick = ref_pick(sv_mask, m_last);
          if (!enable || pick == 0) m_phase = P_IDLE;
          else begin
            m_sv = pick; m_last = pick; m_cnt = 0; m_phase = P_RUN;
          end
        end
        P_RUN: begin
          if (m_done) begin
            m_res = {SV_NUM_W'(m_sv), gps_ca_code, gps_p_code, gps_l_code};
            exp_q.push_back(m_res);
            m_phase = P_HOLD;
          end else begin
`ifdef GPS_SCHED_TIMEOUT_EN
            if (m_cnt == TO_CYC - 1) begin
              m_fire = 1'b1;
              m_phase = enable ? P_SELECT : P_IDLE;
            end else m_cnt++;
`endif
          end
        end
        default: if (res_if.res_ready) m_phase = enable ? P_SELECT : P_IDLE;
      endcase
`ifdef GPS_SCHED_TIMEOUT_EN
      if (m_fire) begin m_terr = 1'b1; m_tsv = m_sv; end
      else if (err_clr) m_terr = 1'b0;
`endif
    end
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  always @(negedge clk) begin
    chk("gps_start", W'(gps_start), W'(m_phase == P_RUN));
    chk("res_valid", W'(res_if.res_valid), W'(m_phase == P_HOLD));
    chk("busy", W'(busy), W'(m_phase != P_IDLE));
    chk("gps_sv_num", W'(gps_sv_num), W'(m_sv));
    chk("res_word", {res_if.res_sv, res_if.res_ca, res_if.res_p, res_if.res_l}, m_res);
    chk("timeout_err", W'(timeout_err), W'(m_terr));
    chk("timeout_sv", W'(timeout_sv), W'(m_tsv));
    if (!rst && res_if.res_valid && res_if.res_ready) begin
      chk("sb_nonempty", W'(exp_q.size() != 0), W'(1));
      if (exp_q.size() != 0)
        chk("sb_result", {res_if.res_sv, res_if.res_ca, res_if.res_p, res_if.res_l},
            exp_q.pop_front());
      served_q.push_back(int'(res_if.res_sv));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_cond(input string name, input int kind, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      case (kind)
        0: ok = res_if.res_valid;
        1: ok = gps_start;
        2: ok = !busy;
        default: ok = timeout_err;
      endcase
    end
    chk(name, W'(ok), W'(1));
  endtask

  task automatic wait_served(input string name, input int n, input int budget);
    for (int i = 0; i < budget && served_q.size() < n; i++) @(negedge clk);
    chk(name, W'(served_q.size() >= n), W'(1));
  endtask

  // ---------------- stimulus ----------------
  int k, cnt, run_cnt;
  logic seen, prev_busy, dbl;

  initial begin
    enable = 1'b0; sv_mask = '0; err_clr = 1'b0; res_if.res_ready = 1'b0;
    step(3);
    @(negedge clk);
    chk("rst_start", W'(gps_start), W'(0));
    chk("rst_valid", W'(res_if.res_valid), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_svnum", W'(gps_sv_num), W'(0));
    chk("rst_res_p", W'(res_if.res_p), W'(0));
    rst = 1'b0;
    step(2);

    // SVs 1 and 3 alternate, ready held high.
    served_q.delete();
    sv_mask = 32'h0000_0005; res_if.res_ready = 1'b1; enable = 1'b1;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); k++;
      if (gps_start) break;
    end
    chk("start_latency", W'(k), W'(3));
    wait_served("t1_wait", 3, 1000);
    chk("t1_sv0", W'(served_q[0]), W'(1));
    chk("t1_sv1", W'(served_q[1]), W'(3));
    chk("t1_sv2", W'(served_q[2]), W'(1));

    // Back-pressure for 50 cycles in HOLD.
    step(1);
    res_if.res_ready = 1'b0;
    wait_cond("t2_wait_valid", 0, 400);
    seen = 1'b0; dbl = 1'b0;
    repeat (50) begin
      @(negedge clk);
      seen |= gps_start;
      dbl  |= !res_if.res_valid;
    end
    chk("t2_no_start", W'(seen), W'(0));
    chk("t2_valid_held", W'(dbl), W'(0));
    step(1);
    res_if.res_ready = 1'b1; enable = 1'b0;
    wait_cond("t2_idle", 2, 400);

    // Empty mask: busy flickers for one cycle per SELECT, core never started.
    step(1);
    sv_mask = '0; enable = 1'b1;
    seen = 1'b0; cnt = 0; prev_busy = 1'b0; dbl = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= gps_start;
      if (busy) cnt++;
      dbl |= busy && prev_busy;
      prev_busy = busy;
    end
    chk("t3_no_start", W'(seen), W'(0));
    chk("t3_busy_cnt", W'(cnt), W'(5));
    chk("t3_busy_1cyc", W'(dbl), W'(0));
    step(1);
    enable = 1'b0;
    wait_cond("t3_idle", 2, 20);

    // Enable dropped while SV 7 runs.
    step(1);
    served_q.delete();
    sv_mask = 32'h0000_0040; enable = 1'b1;
    wait_cond("t4_start", 1, 20);
    step(5);
    enable = 1'b0;
    wait_served("t4_wait", 1, 400);
    chk("t4_sv", W'(served_q[0]), W'(7));
    step(2);
    @(negedge clk);
    chk("t4_busy", W'(busy), W'(0));
    chk("t4_start_off", W'(gps_start), W'(0));

`ifdef GPS_SCHED_TIMEOUT_EN
    // SV 5 never completes; SV 6 is served after the timeout.
    step(1);
    served_q.delete();
    sv_mask = 32'h0000_0030; stall_mask = 32'h0000_0010; enable = 1'b1;
    run_cnt = 0;
    for (int i = 0; i < 100 && !timeout_err; i++) begin
      @(negedge clk);
      if (gps_start && !timeout_err) run_cnt++;
    end
    chk("t5_run_cycles", W'(run_cnt), W'(TO_CYC));
    chk("t5_err", W'(timeout_err), W'(1));
    chk("t5_sv", W'(timeout_sv), W'(5));
    wait_served("t5_wait", 1, 200);
    chk("t5_next_sv", W'(served_q[0]), W'(6));
    step(1);
    enable = 1'b0;
    wait_cond("t5_idle", 2, 200);
    step(1);
    stall_mask = '0; err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    @(negedge clk);
    chk("t5_clr", W'(timeout_err), W'(0));
`endif

    // Reset while holding a result.
    step(1);
    sv_mask = 32'h0000_000A; res_if.res_ready = 1'b0; enable = 1'b1;
    wait_cond("t6_wait_valid", 0, 400);
    step(1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_valid", W'(res_if.res_valid), W'(0));
    chk("t6_start", W'(gps_start), W'(0));
    chk("t6_busy", W'(busy), W'(0));
    chk("t6_res", {res_if.res_sv, res_if.res_ca, res_if.res_p, res_if.res_l}, W'(0));
    chk("t6_svnum", W'(gps_sv_num), W'(0));
    step(1);
    served_q.delete();
    rst = 1'b0; res_if.res_ready = 1'b1;
    wait_served("t6_wait", 1, 400);
    chk("t6_first_sv", W'(served_q[0]), W'(2));

    // Randomized traffic.
    spur_en = 1'b1;
    for (int it = 0; it < 200; it++) begin
      step(1);
      if ($urandom_range(0, 3) == 0)
        sv_mask = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom & $urandom);
      enable           = ($urandom_range(0, 9) != 0);
      res_if.res_ready = ($urandom_range(0, 3) != 0);
      err_clr          = ($urandom_range(0, 15) == 0);
      core_delay       = $urandom_range(1, 30);
      step($urandom_range(1, 15));
    end
    spur_en = 1'b0; enable = 1'b0; res_if.res_ready = 1'b1; err_clr = 1'b0;
    wait_cond("rand_drain", 2, 500);
    step(2);
    @(negedge clk);
    chk("rand_sb_empty", W'(exp_q.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
